sram_a_streamer: RTL

// - Read-side sequencer for the 1024x8 matrix-A SRAM (1-cycle registered read, ce/we/addr/din/dout).
// - Walks a rows x cols tile of A at base/stride and issues SRAM reads.
// - Absorbs the SRAM read latency and streams bytes to the PE-array input over valid/ready.
// - Sits directly downstream of the A SRAM; never writes it.

---
 rtl/sram_a_streamer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/sram_a_streamer.sv
// Purpose: walks a rows x cols tile of the matrix-A SRAM and streams its bytes out row-major; optional stall counter under A_STREAM_STALL_CNT_EN.
// Latency: start accepted at edge 0 -> sram_ce in cycle 1 -> out_valid in cycle 3; 1 beat/cycle sustained.
// Backpressure: valid/ready output with a 4-entry FIFO; reads are issued only while FIFO occupancy + reads in flight < 4.
module sram_a_streamer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int DIM_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  rows,
    input  logic [DIM_W-1:0]  cols,
    input  logic [DIM_W-1:0]  stride,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last_col,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic              lc;
        logic              last;
    } beat_t;

    localparam logic [DIM_W-1:0]  ONE_D = DIM_W'(1);
    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

    state_t              state;
    logic [DIM_W-1:0]    c_q, r_q, rows_q, cols_q, stride_q;
    logic [ADDR_W-1:0]   addr_q, rowb_q;
    logic                ce_lc, ce_last;
    logic                rd_vld, rd_lc, rd_last;
    beat_t               fifo_mem [4];
    logic [1:0]          wr_ptr, rd_ptr;
    logic [2:0]          fifo_cnt;
    beat_t               head;

    logic                abort_act, start_acc, job_ok, pop, credit_ok, issue;
    logic                lc_cur, last_cur;
    logic [DIM_W-1:0]    c_cur, r_cur, rows_cur, cols_cur, stride_cur;
    logic [ADDR_W-1:0]   addr_cur, rowb_cur, next_rowb;
    logic [3:0]          outstanding;

    assign sram_we      = 1'b0;
    assign sram_din     = '0;
    assign head         = fifo_mem[rd_ptr];
    assign out_valid    = (fifo_cnt != 3'd0);
    assign out_data     = head.dat;
    assign out_last_col = head.lc;
    assign out_last     = head.last;

    // Issue decision: in IDLE the walk position comes straight from the start inputs so the first read goes out on the start edge.
    always_comb begin
        abort_act   = abort && (state != S_IDLE);
        start_acc   = start && !abort && (state == S_IDLE);
        job_ok      = (rows != '0) && (cols != '0);
        pop         = out_valid && out_ready;
        c_cur       = c_q;
        r_cur       = r_q;
        rows_cur    = rows_q;
        cols_cur    = cols_q;
        stride_cur  = stride_q;
        addr_cur    = addr_q;
        rowb_cur    = rowb_q;
        if (state == S_IDLE) begin
            c_cur      = '0;
            r_cur      = '0;
            rows_cur   = rows;
            cols_cur   = cols;
            stride_cur = stride;
            addr_cur   = base_addr;
            rowb_cur   = base_addr;
        end
        lc_cur      = (c_cur == cols_cur - ONE_D);
        last_cur    = lc_cur && (r_cur == rows_cur - ONE_D);
        next_rowb   = rowb_cur + {{(ADDR_W-DIM_W){1'b0}}, stride_cur};
        outstanding = {1'b0, fifo_cnt} + {3'b000, sram_ce} + {3'b000, rd_vld} - {3'b000, pop};
        credit_ok   = (outstanding < 4'd4);
        issue       = (start_acc && job_ok) || ((state == S_RUN) && !abort && credit_ok);
    end

    // Job FSM, tile walk counters and registered SRAM request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sram_ce   <= 1'b0;
            sram_addr <= '0;
            ce_lc     <= 1'b0;
            ce_last   <= 1'b0;
            c_q       <= '0;
            r_q       <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            stride_q  <= '0;
            addr_q    <= '0;
            rowb_q    <= '0;
        end else begin
            done    <= 1'b0;
            sram_ce <= issue;
            if (issue) begin
                sram_addr <= addr_cur;
                ce_lc     <= lc_cur;
                ce_last   <= last_cur;
                if (lc_cur) begin
                    c_q    <= '0;
                    r_q    <= r_cur + ONE_D;
                    rowb_q <= next_rowb;
                    addr_q <= next_rowb;
                end else begin
                    c_q    <= c_cur + ONE_D;
                    r_q    <= r_cur;
                    rowb_q <= rowb_cur;
                    addr_q <= addr_cur + ONE_A;
                end
            end
            if (start_acc) begin
                rows_q   <= rows;
                cols_q   <= cols;
                stride_q <= stride;
            end
            case (state)
                S_IDLE: begin
                    if (start_acc) begin
                        busy <= 1'b1;
                        if (!job_ok) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (last_cur) begin
                            state <= S_DRAIN;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (issue && last_cur) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (abort || (pop && head.last)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read-data capture one cycle after sram_ce, then into the output FIFO; abort discards both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld   <= 1'b0;
            rd_lc    <= 1'b0;
            rd_last  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
        end else begin
            rd_vld  <= sram_ce && !abort_act;
            rd_lc   <= ce_lc;
            rd_last <= ce_last;
            if (abort_act) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                if (rd_vld) begin
                    fifo_mem[wr_ptr] <= '{dat: sram_dout, lc: rd_lc, last: rd_last};
                    wr_ptr           <= wr_ptr + 2'd1;
                end
                if (pop) rd_ptr <= rd_ptr + 2'd1;
                fifo_cnt <= fifo_cnt + {2'b00, rd_vld} - {2'b00, pop};
            end
        end
    end

`ifdef A_STREAM_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of cycles the consumer held off a valid beat; restarts with each accepted job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
